// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: shared types and address-step helper for the flash reader.
package flash_reader_pkg;

  // Controller FSM encoding; fixed 2-bit values so traces stay readable.
  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    REQ       = 2'd2,
    WAIT_DATA = 2'd3
  } state_e;

  // One-deep step request recorded from the buttons or the scan timer.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2
  } step_e;

  // Wrapped address step. Arithmetic is done at 32 bits, wider than any
  // practical address, so cur +/- step can never wrap through truncation;
  // the only wrap points are last -> 0 going forward and 0 -> last going back.
  function automatic logic [31:0] step_addr(input logic [31:0] cur,
                                            input step_e       dir,
                                            input logic [31:0] step,
                                            input logic [31:0] last);
    logic [31:0] nxt;
    nxt = cur;
    case (dir)
      FWD:     nxt = (cur == last)  ? 32'd0 : cur + step;
      BWD:     nxt = (cur == 32'd0) ? last  : cur - step;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/flash_reader_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and press pulse for one
// active-low pushbutton. The debounced level only follows the synchronised
// input after DEB_CYCLES consecutive samples that differ from it.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clk domain; idle level is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples disagreeing with the stable level; any agreeing
  // sample restarts the count so short glitches never reach the output.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) stable_d = sync2_q;
      else                                 cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // One-clock pulse on the debounced 1->0 (press) transition.
  assign press = stable_q & ~stable_d;

endmodule

// File: rtl/flash_reader_ctrl.sv
// flash_reader_ctrl: Avalon-MM read master that browses flash one word at a
// time under pushbutton control, with wrap-around and a read timeout.
// Optional feature macro: FLASH_READER_AUTO_SCAN_EN adds an auto_scan input
// that steps forward every SCAN_PERIOD idle clocks.
module flash_reader_ctrl
  import flash_reader_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int ADDR_STEP      = 4,
  parameter int ADDR_LAST      = 16380,
  parameter int DEB_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SCAN_PERIOD    = 5000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_next,
  input  logic              btn_prev,
`ifdef FLASH_READER_AUTO_SCAN_EN
  input  logic              auto_scan,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Elaboration-time parameter sanity.
  if (ADDR_LAST % ADDR_STEP != 0) begin : g_bad_last
    $error("ADDR_LAST must be a multiple of ADDR_STEP");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || SCAN_PERIOD < 1) begin : g_bad_period
    $error("TIMEOUT_CYCLES and SCAN_PERIOD must be positive");
  end

  state_e             state_q, state_d;
  step_e              pend_q, pend_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dv_q, dv_d;
  logic               terr_q, terr_d;
  logic [TMO_W-1:0]   tcnt_q, tcnt_d;
  logic               pend_take;
  logic               nxt_press, prv_press, scan_step;
  logic               step_fwd, step_bwd;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk    (clk),
    .resetn (resetn),
    .btn_n  (btn_next),
    .press  (nxt_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk    (clk),
    .resetn (resetn),
    .btn_n  (btn_prev),
    .press  (prv_press)
  );

`ifdef FLASH_READER_AUTO_SCAN_EN
  localparam int SCAN_W = $clog2(SCAN_PERIOD + 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

  // Scan timer advances only while idle and is cleared whenever scanning is off.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    scan_step  = 1'b0;
    if (!auto_scan) begin
      scan_cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (scan_cnt_q == SCAN_W'(SCAN_PERIOD - 1)) begin
        scan_cnt_d = '0;
        scan_step  = 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end
    end
  end

  // Scan timer register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) scan_cnt_q <= '0;
    else         scan_cnt_q <= scan_cnt_d;
  end
`else
  assign scan_step = 1'b0;
`endif

  // Simultaneous next+prev cancels out; any button event outranks the scan tick.
  assign step_fwd = (nxt_press & ~prv_press) | (scan_step & ~nxt_press & ~prv_press);
  assign step_bwd = prv_press & ~nxt_press;

  // Pending step: a fresh event always wins over consuming the old one.
  always_comb begin
    pend_d = pend_q;
    if (pend_take) pend_d = NONE;
    if (step_fwd)      pend_d = FWD;
    else if (step_bwd) pend_d = BWD;
  end

  // Read sequencing: request held through waitrequest, data or timeout ends it.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    data_d     = data_q;
    dv_d       = dv_q;
    terr_d     = terr_q;
    tcnt_d     = tcnt_q;
    pend_take  = 1'b0;
    case (state_q)
      INIT: begin
        cur_addr_d = '0;
        addr_d     = '0;
        rd_d       = 1'b1;
        state_d    = REQ;
      end
      IDLE: begin
        if (pend_q != NONE) begin
          cur_addr_d = ADDR_W'(step_addr(32'(cur_addr_q), pend_q,
                                         32'(ADDR_STEP), 32'(ADDR_LAST)));
          addr_d     = cur_addr_d;
          rd_d       = 1'b1;
          dv_d       = 1'b0;
          pend_take  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          rd_d   = 1'b0;
          tcnt_d = '0;
          // A zero-latency slave may return data on the acceptance cycle.
          if (avm_readdatavalid) begin
            data_d  = avm_readdata;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
          dv_d    = 1'b1;
          state_d = IDLE;
        end else if (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up: keep the old word but leave data_valid low.
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Controller state and bus-facing registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      pend_q     <= NONE;
      cur_addr_q <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      terr_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_addr_q <= cur_addr_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      terr_q     <= terr_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = rd_q;
  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign cur_addr    = cur_addr_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q == REQ) || (state_q == WAIT_DATA);

endmodule
